pipe_credit_fifo: RTL and testbench

- Sits directly downstream of a fixed-latency, non-stallable pipeline delay stage.
- That stage cannot be stalled, so every sample launched into it must have guaranteed buffer space on exit.
- This block tracks samples in flight through the delay stage, buffers what emerges in a DEPTH-entry FIFO, and presents a valid/ready stream to a back-pressuring consumer.
- It issues a launch credit to the upstream producer only when space is guaranteed.

---
 rtl/pipe_credit_fifo_if.sv | 30 +++
 rtl/pipe_credit_fifo.sv | 109 ++++++++++
 tb/tb_pipe_credit_fifo.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_credit_fifo_if.sv
// Stream, credit and status signals between pipe_credit_fifo and its producer/consumer side.
// The fifo uses the slave modport; the master modport drives it.
interface pipe_credit_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             issue_in;
    logic             can_issue_out;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             flush_in;
    logic [CW-1:0]    count_out;
    logic [CW-1:0]    inflight_out;
    logic             err_out;

    modport slave (
        input  issue_in, in_valid, in_data, out_ready, flush_in,
        output can_issue_out, out_valid, out_data, count_out, inflight_out, err_out
    );

    modport master (
        output issue_in, in_valid, in_data, out_ready, flush_in,
        input  can_issue_out, out_valid, out_data, count_out, inflight_out, err_out
    );
endinterface

// File: rtl/pipe_credit_fifo.sv
// Credit-gated FIFO behind a fixed-latency, non-stallable delay stage.
// A launch credit is granted only while buffered + in-flight samples stay below DEPTH.
module pipe_credit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    pipe_credit_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic             out_valid_q;
    logic             err_q;

    logic [CW:0]      occupancy;
    logic             can_issue;
    logic             issue_acc;
    logic             issue_err;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic             underflow;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    inflight_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit is derived from registered state only, so the producer sees no input-to-output path.
    always_comb begin
        occupancy = {1'b0, count} + {1'b0, inflight};
        can_issue = occupancy < {1'b0, DEPTH_C};
        issue_acc = bus.issue_in && can_issue;
        issue_err = bus.issue_in && !can_issue;
        full      = (count == DEPTH_C);
        pop       = out_valid_q && bus.out_ready && !bus.flush_in;
        push      = bus.in_valid && !bus.flush_in && (!full || pop);
        drop      = bus.in_valid && !bus.flush_in && full && !pop;
        underflow = bus.in_valid && (inflight == '0) && !issue_acc;
    end

    always_comb begin
        inflight_nxt = inflight;
        unique case ({issue_acc, bus.in_valid})
            2'b10:   inflight_nxt = inflight + 1'b1;
            2'b01:   inflight_nxt = (inflight == '0) ? '0 : inflight - 1'b1;
            default: inflight_nxt = inflight;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (bus.flush_in) begin
            count_nxt = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count       <= '0;
            inflight    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count       <= count_nxt;
            inflight    <= inflight_nxt;
            out_valid_q <= (count_nxt != '0);
            if (bus.flush_in) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push) wr_ptr <= ptr_inc(wr_ptr);
            end
            if (issue_err || drop || underflow) err_q <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; out_data is only meaningful while out_valid.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    assign bus.can_issue_out = can_issue;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = mem[rd_ptr];
    assign bus.count_out     = count;
    assign bus.inflight_out  = inflight;
    assign bus.err_out       = err_q;
endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Directed and randomized bench for pipe_credit_fifo; the bench models the delay stage itself
// and predicts behaviour with a queue-based reference model.
module tb_pipe_credit_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        int         due;
        logic [7:0] d;
    } arr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_credit_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         lat = 3;
    arr_t       arr_q[$];
    logic [7:0] mq[$];
    logic [7:0] rx[$];
    int         infl = 0;
    bit         merr = 1'b0;
    bit         last_can = 1'b0;
    bit         acc;
    int         n_acc;
    int         first_i;
    int         first_v;
    int         drops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        arr_q.delete();
        infl = 0;
        merr = 1'b0;
    endtask

    task automatic do_reset();
        bus.issue_in  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush_in  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs (delay-stage arrivals come from arr_q), advance the model, check all outputs.
    task automatic step(input bit want, input bit obey, input bit rdy, input bit fl,
                        input bit fv, input logic [7:0] fd, input logic [7:0] idat,
                        output bit acc_o);
        bit         exp_can;
        bit         iv;
        bit         pop;
        bit         full_b;
        logic [7:0] ivd;
        exp_can = (mq.size() + infl) < DEPTH;
        iv  = fv;
        ivd = fd;
        if (arr_q.size() > 0 && arr_q[0].due == cyc) begin
            iv  = 1'b1;
            ivd = arr_q[0].d;
            void'(arr_q.pop_front());
        end
        bus.issue_in  = want && (exp_can || !obey);
        bus.in_valid  = iv;
        bus.in_data   = iv ? ivd : 8'($urandom);
        bus.out_ready = rdy;
        bus.flush_in  = fl;
        last_can = bus.can_issue_out;
        chk("can_issue", bus.can_issue_out, exp_can);
        acc_o = bus.issue_in && exp_can;
        if (acc_o) arr_q.push_back('{due: cyc + lat, d: idat});
        if (bus.out_valid && rdy && !fl) rx.push_back(bus.out_data);

        if (bus.issue_in && !exp_can) merr = 1'b1;
        if (acc_o && !iv) infl++;
        else if (iv && !acc_o) begin
            if (infl == 0) merr = 1'b1;
            else infl--;
        end
        pop    = (mq.size() > 0) && rdy && !fl;
        full_b = (mq.size() == DEPTH);
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (iv) begin
                if (full_b && !pop) merr = 1'b1;
                else mq.push_back(ivd);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("count", bus.count_out, mq.size());
        chk("inflight", bus.inflight_out, infl);
        chk("out_valid", bus.out_valid, mq.size() > 0);
        chk("err", bus.err_out, merr);
        if (mq.size() > 0) chk("out_data", bus.out_data, mq[0]);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit a;
        repeat (n) step(1'b0, 1'b1, rdy, 1'b0, 1'b0, 8'h00, 8'h00, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_count", bus.count_out, 0);
        chk("rst_inflight", bus.inflight_out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err", bus.err_out, 0);
        chk("rst_can_issue", bus.can_issue_out, 1);

        // credit exhaustion
        lat = 3;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'(8'h40 + i), acc);
            if (acc) n_acc++;
        end
        chk("exhaust_accepted", n_acc, 4);
        chk("exhaust_count", bus.count_out, 4);
        chk("exhaust_can_issue", bus.can_issue_out, 0);
        chk("exhaust_err", bus.err_out, 0);
        rx.delete();
        idle(6, 1'b1);
        chk("exhaust_rx_len", rx.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rx.size()) chk("exhaust_order", rx[i], 8'h40 + i);

        // streaming 0x01..0x20
        rx.delete();
        n_acc = 0;
        first_i = -1;
        first_v = -1;
        for (int i = 0; i < 70; i++) begin
            step(n_acc < 32, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'(n_acc + 1), acc);
            if (acc) begin
                if (first_i < 0) first_i = cyc - 1;
                n_acc++;
            end
            if (bus.out_valid && first_v < 0) first_v = cyc;
        end
        chk("stream_issued", n_acc, 32);
        chk("stream_latency", first_v - first_i, 4);
        chk("stream_rx_len", rx.size(), 32);
        for (int i = 0; i < 32; i++)
            if (i < rx.size()) chk("stream_order", rx[i], i + 1);
        chk("stream_err", bus.err_out, 0);

        // sustained issue at lat < DEPTH-1
        lat = 2;
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'($urandom), acc);
            if (!last_can) drops++;
        end
        chk("throughput_drops", drops, 0);
        idle(6, 1'b1);

        // flush with samples still in flight
        lat = 3;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, acc);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h22, acc);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33, acc);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44, acc);
        chk("pre_flush_count", bus.count_out, 2);
        chk("pre_flush_inflight", bus.inflight_out, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, acc);
        chk("flush_count", bus.count_out, 0);
        chk("flush_inflight", bus.inflight_out, 2);
        chk("flush_out_valid", bus.out_valid, 0);
        rx.delete();
        idle(6, 1'b1);
        chk("flush_rx_len", rx.size(), 2);
        if (rx.size() == 2) begin
            chk("flush_rx0", rx[0], 8'h33);
            chk("flush_rx1", rx[1], 8'h44);
        end
        chk("flush_err", bus.err_out, 0);

        // randomized traffic from a credit-respecting producer
        for (int ph = 0; ph < 4; ph++) begin
            lat = $urandom_range(1, 3);
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0, 1'b0, 8'h00, 8'($urandom), acc);
            idle(lat + 6, 1'b1);
        end
        chk("random_err", bus.err_out, 0);

        // issue without credit, then full push with simultaneous pop
        lat = 3;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'(8'h50 + i), acc);
        idle(4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, acc);
        chk("viol_issue_err", bus.err_out, 1);
        chk("viol_issue_inflight", bus.inflight_out, 0);
        chk("viol_issue_count", bus.count_out, 4);
        rx.delete();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, acc);
        chk("fullpp_count", bus.count_out, 4);
        idle(6, 1'b1);
        chk("fullpp_rx_len", rx.size(), 5);
        if (rx.size() == 5) begin
            chk("fullpp_head", rx[0], 8'h50);
            chk("fullpp_tail", rx[4], 8'hAA);
        end

        // arrival with nothing in flight
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5C, 8'h00, acc);
        chk("underflow_err", bus.err_out, 1);
        chk("underflow_inflight", bus.inflight_out, 0);

        // asynchronous reset in the middle of traffic
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'(8'h60 + i), acc);
        idle(2, 1'b0);
        chk("mid_count", bus.count_out, 2);
        chk("mid_inflight", bus.inflight_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_count", bus.count_out, 0);
        chk("async_rst_inflight", bus.inflight_out, 0);
        chk("async_rst_err", bus.err_out, 0);
        chk("async_rst_can_issue", bus.can_issue_out, 1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
